uart_receiver: RTL and testbench

Serial-to-parallel UART receiver (8N1, LSB first) on the board's uart_rx pin; the upstream counterpart of the transmitter that drives uart_tx. Synchronises the line, samples each bit at mid-bit, and holds one received byte for the CPU I/O read path with a valid/ready handshake. Reports framing errors and overruns as sticky flags.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_receiver.sv | 145 ++++++++++++++
 tb/tb_uart_receiver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int MIN_WAIT  = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make the two-stage shift independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with valid/ready output and sticky frame_err/overrun flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int WAIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err
);

  localparam int             CW       = $clog2(WAIT);
  localparam logic [CW-1:0]  BIT_LAST = CW'(WAIT - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 sample;
  uart_rx_state_t       state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 deliver;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle after the centre sample, so the start wait is one cycle longer.
  localparam logic [CW-1:0] START_LAST = CW'(WAIT / 2);
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (reset) hist <= 2'b11;
    else       hist <= {hist[0], rx_s};
  end

  assign sample = maj3(hist[1], hist[0], rx_s);
`else
  localparam logic [CW-1:0] START_LAST = CW'(WAIT / 2 - 1);
  assign sample = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      deliver   <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      deliver <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      // Later writes below win, so a same-cycle error event beats clr_err.
      if (clr_err) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == START_LAST) begin
            cnt <= '0;
            if (sample) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= sample;
            if (bit_idx == LAST_BIT) state   <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (sample) begin
              state   <= IDLE;
              busy    <= 1'b0;
              deliver <= 1'b1;
            end else begin
              state     <= BREAK;
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at WAIT=8; frames are bit-banged cycle by cycle.
module tb_uart_receiver;

  localparam int W = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_NOM = 2 + W / 2 + 9 * W + 1 + 1;
`else
  localparam int LAT_NOM = 2 + W / 2 + 9 * W + 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_receiver #(.WAIT(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one frame; all inputs change right after a falling edge.
  // ready_at/busy_at/reset_at are cycle indices within the frame, -1 disables.
  task automatic run_frame(input logic [7:0] b, input int stop_bits, input logic stop_level,
                           input int ready_at, input int busy_at, input int reset_at);
    int total;
    int pos;
    logic was_valid;
    total = (9 + stop_bits) * W + 8;
    was_valid = valid;
    lat = -1;
    for (int i = 0; i < total; i++) begin
      pos = i / W;
      if (pos == 0)                   uart_rx = 1'b0;
      else if (pos <= 8)              uart_rx = b[pos-1];
      else if (pos <= 8 + stop_bits)  uart_rx = stop_level;
      else                            uart_rx = 1'b1;
      ready = (i == ready_at);
      reset = (reset_at >= 0) && (i >= reset_at) && (i < reset_at + 2);
      @(negedge clk);
      if (!was_valid && valid && lat < 0) lat = i + 1;
      if (i == busy_at) check("busy_mid", busy, 1);
    end
    ready = 1'b0;
    reset = 1'b0;
  endtask

  task automatic expect_byte(input string tag);
    int n;
    n = 0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!valid) check({tag, "_valid_timeout"}, 0, 1);
    else if (exp_q.size() == 0) check({tag, "_queue_empty"}, 0, 1);
    else check(tag, data, exp_q.pop_front());
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    uart_rx = 1'b1;
    ready   = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);

    // 0x5A with ready held low
    exp_q.push_back(8'h5A);
    run_frame(8'h5A, 1, 1'b1, -1, 40, -1);
    check("lat_in_window", (lat >= LAT_NOM - 1) && (lat <= LAT_NOM + 1), 1);
    expect_byte("data_5a");
    check("busy_after_5a", busy, 0);
    check("fe_after_5a", frame_err, 0);
    check("ov_after_5a", overrun, 0);
    pulse_ready();
    check("valid_cleared_5a", valid, 0);

    // 3-cycle glitch must be rejected as a false start
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_valid", valid, 0);
    check("glitch_busy", busy, 0);
    check("glitch_fe", frame_err, 0);
    check("glitch_ov", overrun, 0);
    exp_q.push_back(8'hA5);
    run_frame(8'hA5, 1, 1'b1, -1, 40, -1);
    expect_byte("data_a5");
    pulse_ready();

    // stop bit held low for two bit times: framing error then BREAK
    run_frame(8'h3C, 2, 1'b0, -1, 86, -1);
    check("fe_set", frame_err, 1);
    check("fe_valid", valid, 0);
    check("fe_busy_after", busy, 0);
    pulse_clr();
    check("fe_cleared", frame_err, 0);

    // two frames unread: overrun keeps the first byte
    exp_q.push_back(8'h11);
    run_frame(8'h11, 1, 1'b1, -1, -1, -1);
    run_frame(8'h22, 1, 1'b1, -1, -1, -1);
    expect_byte("data_kept_11");
    check("ov_set", overrun, 1);
    pulse_ready();
    check("ov_valid_cleared", valid, 0);
    pulse_clr();
    check("ov_cleared", overrun, 0);

    // ready coincides with the second delivery: no overrun
    exp_q.push_back(8'h11);
    run_frame(8'h11, 1, 1'b1, -1, -1, -1);
    expect_byte("b2b_data_11");
    exp_q.push_back(8'h22);
    run_frame(8'h22, 1, 1'b1, LAT_NOM - 1, -1, -1);
    check("b2b_valid", valid, 1);
    expect_byte("b2b_data_22");
    check("b2b_ov", overrun, 0);

    // reset after bit 3 of 0xFF aborts the frame
    run_frame(8'hFF, 1, 1'b1, -1, -1, 5 * W);
    check("mid_rst_data", data, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fe", frame_err, 0);
    check("mid_rst_ov", overrun, 0);
    exp_q.push_back(8'h81);
    run_frame(8'h81, 1, 1'b1, -1, 40, -1);
    expect_byte("data_81");
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
